// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq_if
// Purpose  : Request/result bundle for the sequential binary-to-BCD converter.
//            The master issues start/bin and observes busy/done/bcd/overflow.
// Revision : 1.0  initial release
// ============================================================================
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  // Requester side (datapath / testbench)
  modport master (
    output start,
    output bin,
    input  busy,
    input  done,
    input  bcd,
    input  overflow
  );

  // Converter side
  modport slave (
    input  start,
    input  bin,
    output busy,
    output done,
    output bcd,
    output overflow
  );
endinterface
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Sequential shift-and-add-3 binary-to-BCD converter. One operand
//            per accepted start; result after BIN_W shift cycles plus one
//            result-register cycle. Values above 10**DIGITS-1 saturate to
//            all 9s and raise overflow.
// Options  : LEADING_ZERO_BLANK_EN - replace leading zero digits (never digit 0)
//            with the blank code 4'hF in the registered result.
// Revision : 1.0  initial release
// ============================================================================
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bin_to_bcd_seq_if.slave     bus
);

  localparam int c_bcd_w = 4 * DIGITS;
  localparam int c_scr_w = c_bcd_w + 1;          // one guard bit above the top digit
  localparam int c_cnt_w = $clog2(BIN_W + 1);

  // 10**n evaluated at elaboration time, wide enough for any legal DIGITS
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) begin
      v = v * 64'd10;
    end
    return v;
  endfunction

  localparam logic [63:0] c_max_val = pow10(DIGITS) - 64'd1;

  // Elaboration-time guard on the supported operand width
  if ((BIN_W < 4) || (BIN_W > 20)) begin : g_param_check
    $error("bin_to_bcd_seq: BIN_W must be within 4..20");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [BIN_W-1:0]     r_shift;
  logic [c_scr_w-1:0]   r_scratch;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_ovf_cap;

  logic                 r_done;
  logic [c_bcd_w-1:0]   r_bcd;
  logic                 r_overflow;

  logic                 w_accept;
  logic [c_bcd_w-1:0]   w_adj;
  logic [c_bcd_w-1:0]   w_formatted;
  logic [c_bcd_w-1:0]   w_result;
  logic                 w_sat;

  assign w_accept = (r_state == S_IDLE) && bus.start;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: IDLE waits for start, SHIFT runs BIN_W cycles, DONE lasts one
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == c_cnt_w'(1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Add-3 correction applied to every scratch digit in parallel before the shift
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign w_adj[4*d +: 4] = (r_scratch[4*d +: 4] >= 4'd5) ? (r_scratch[4*d +: 4] + 4'd3)
                                                          : r_scratch[4*d +: 4];
  end

  // Conversion datapath: load on accept, shift {scratch, shift} left while in SHIFT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf_cap <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= bus.bin;
      r_scratch <= '0;
      r_cnt     <= c_cnt_w'(BIN_W);
      r_ovf_cap <= ({{(64-BIN_W){1'b0}}, bus.bin} > c_max_val);
    end else if (r_state == S_SHIFT) begin
      // Old guard bit falls off the top; the new guard is the top adjusted bit
      r_scratch <= {w_adj, r_shift[BIN_W-1]};
      r_shift   <= {r_shift[BIN_W-2:0], 1'b0};
      r_cnt     <= r_cnt - c_cnt_w'(1);
    end
  end

  // The guard bit can only be set by an out-of-range operand, which ovf_cap already
  // flags; folding it in keeps saturation robust without changing in-range results.
  assign w_sat = r_ovf_cap | r_scratch[c_bcd_w];

`ifdef LEADING_ZERO_BLANK_EN
  // Blank zero digits above the most-significant nonzero digit; digit 0 always shown
  always_comb begin
    logic v_lead;
    w_formatted = r_scratch[c_bcd_w-1:0];
    v_lead      = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (v_lead && (r_scratch[4*d +: 4] == 4'd0)) begin
        w_formatted[4*d +: 4] = 4'hF;
      end else begin
        v_lead = 1'b0;
      end
    end
  end
`else
  assign w_formatted = r_scratch[c_bcd_w-1:0];
`endif

  assign w_result = w_sat ? {DIGITS{4'd9}} : w_formatted;

  // Result registers: updated only in DONE so intermediate scratch never leaks out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        r_bcd      <= w_result;
        r_overflow <= w_sat;
      end
    end
  end

  assign bus.busy     = (r_state == S_SHIFT);
  assign bus.done     = r_done;
  assign bus.bcd      = r_bcd;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire
